// File: rtl/board_checker.sv
// Tic-tac-toe move resolver: validates and commits moves on a 3x3 board,
// then scores all eight lines for a win or a tie.
module board_checker (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        move_valid_i,
  input  logic [3:0]  move_i,
  input  logic        player_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        accepted_o,
  output logic [1:0]  outcome_o,
  output logic        game_over_o,
  output logic [17:0] board_o,
  output logic [3:0]  move_count_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WRITE = 3'd2,
    EVAL  = 3'd3,
    RESP  = 3'd4,
    OVER  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  outcome_q, outcome_d;
  logic [3:0]  move_q, move_d;
  logic        player_q, player_d;
  logic        accept_q, accept_d;
  logic [1:0]  sq_s;

  // Marks are one-hot per player, so ANDing a line leaves a bit only if all three match.
  function automatic logic [1:0] line_mark(input logic [17:0] b, input int a, input int c, input int d);
    return b[2*a +: 2] & b[2*c +: 2] & b[2*d +: 2];
  endfunction

  function automatic logic [1:0] find_winner(input logic [17:0] b);
    logic [1:0] any_line;
    any_line = line_mark(b, 0, 1, 2) | line_mark(b, 3, 4, 5) | line_mark(b, 6, 7, 8)
             | line_mark(b, 0, 3, 6) | line_mark(b, 1, 4, 7) | line_mark(b, 2, 5, 8)
             | line_mark(b, 0, 4, 8) | line_mark(b, 2, 4, 6);
    if (any_line[0]) begin
      return 2'b01;
    end else if (any_line[1]) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Contents of the addressed square; out-of-range indices read as empty.
  always_comb begin
    sq_s = 2'b00;
    for (int k = 0; k < 9; k++) begin
      sq_s = (int'(move_q) == k) ? board_q[2*k +: 2] : sq_s;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    count_d   = count_q;
    outcome_d = outcome_q;
    move_d    = move_q;
    player_d  = player_q;
    accept_d  = accept_q;
    case (state_q)
      IDLE, OVER: begin
        if (move_valid_i) begin
          move_d   = move_i;
          player_d = player_i;
          state_d  = CHECK;
        end else begin
          state_d  = state_q;
        end
      end
      CHECK: begin
        // A finished game rejects everything, which routes OVER requests to RESP.
        if ((outcome_q == 2'b00) && (move_q <= 4'd8) && (sq_s == 2'b00)
            && (player_q == count_q[0])) begin
          accept_d = 1'b1;
          state_d  = WRITE;
        end else begin
          accept_d = 1'b0;
          state_d  = RESP;
        end
      end
      WRITE: begin
        for (int k = 0; k < 9; k++) begin
          board_d[2*k +: 2] = (int'(move_q) == k) ? (player_q ? 2'b10 : 2'b01)
                                                  : board_q[2*k +: 2];
        end
        count_d = count_q + 4'd1;
        state_d = EVAL;
      end
      EVAL: begin
        if (find_winner(board_q) != 2'b00) begin
          outcome_d = find_winner(board_q);
        end else if (count_q == 4'd9) begin
          outcome_d = 2'b11;
        end else begin
          outcome_d = outcome_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (outcome_q != 2'b00) begin
          state_d = OVER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      board_q   <= 18'd0;
      count_q   <= 4'd0;
      outcome_q <= 2'b00;
      move_q    <= 4'd0;
      player_q  <= 1'b0;
      accept_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      count_q   <= count_d;
      outcome_q <= outcome_d;
      move_q    <= move_d;
      player_q  <= player_d;
      accept_q  <= accept_d;
    end
  end

  assign busy_o       = (state_q == CHECK) || (state_q == WRITE)
                     || (state_q == EVAL)  || (state_q == RESP);
  assign done_o       = (state_q == RESP);
  assign accepted_o   = (state_q == RESP) && accept_q;
  assign outcome_o    = outcome_q;
  assign game_over_o  = (outcome_q != 2'b00);
  assign board_o      = board_q;
  assign move_count_o = count_q;

endmodule

// File: tb/tb_board_checker.sv
// Self-checking bench for board_checker: table-driven games with a response
// scoreboard, plus hand-written reset, held-request and busy-pulse sequences.
module tb_board_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        move_valid_i;
  logic [3:0]  move_i;
  logic        player_i;
  logic        busy_o, done_o, accepted_o, game_over_o;
  logic [1:0]  outcome_o;
  logic [17:0] board_o;
  logic [3:0]  move_count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst_before;
    logic [3:0] mv;
    logic       pl;
    logic       acc;
    logic [1:0] outc;
  } vec_t;

  typedef struct {
    logic        acc;
    logic [1:0]  outc;
    logic [3:0]  count;
    logic [17:0] board;
    int          latency;
  } exp_t;

  vec_t vecs [29];
  exp_t sb_q [$];
  logic [17:0] m_board;
  logic [3:0]  m_count;

  board_checker dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .move_valid_i (move_valid_i),
    .move_i       (move_i),
    .player_i     (player_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .accepted_o   (accepted_o),
    .outcome_o    (outcome_o),
    .game_over_o  (game_over_o),
    .board_o      (board_o),
    .move_count_o (move_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"}, 32'(busy_o), 32'd0);
    check({tag, ".done"}, 32'(done_o), 32'd0);
    check({tag, ".accepted"}, 32'(accepted_o), 32'd0);
    check({tag, ".game_over"}, 32'(game_over_o), 32'd0);
    check({tag, ".outcome"}, 32'(outcome_o), 32'd0);
    check({tag, ".board"}, 32'(board_o), 32'd0);
    check({tag, ".count"}, 32'(move_count_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    move_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_board = 18'd0;
    m_count = 4'd0;
  endtask

  task automatic run_vec(input int idx, input logic [3:0] mv, input logic pl,
                         input logic acc, input logic [1:0] outc);
    exp_t e;
    exp_t got_e;
    bit   got;
    int   n;
    if (acc) begin
      m_board[2*mv +: 2] = pl ? 2'b10 : 2'b01;
      m_count = m_count + 4'd1;
    end
    e.acc = acc; e.outc = outc; e.count = m_count; e.board = m_board;
    e.latency = acc ? 4 : 2;
    sb_q.push_back(e);
    move_i = mv; player_i = pl; move_valid_i = 1'b1;
    got = 1'b0; n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_i);
      #1;
      if (c == 1) move_valid_i = 1'b0;
      if (done_o && !got) begin
        got = 1'b1;
        n = c;
        break;
      end
    end
    check($sformatf("v%0d.done_seen", idx), 32'(got), 32'd1);
    if (got) begin
      got_e = sb_q.pop_front();
      check($sformatf("v%0d.latency", idx), 32'(n), 32'(got_e.latency));
      check($sformatf("v%0d.accepted", idx), 32'(accepted_o), 32'(got_e.acc));
      check($sformatf("v%0d.outcome", idx), 32'(outcome_o), 32'(got_e.outc));
      check($sformatf("v%0d.game_over", idx), 32'(game_over_o), 32'(got_e.outc != 2'b00));
      check($sformatf("v%0d.count", idx), 32'(move_count_o), 32'(got_e.count));
      check($sformatf("v%0d.board", idx), 32'(board_o), 32'(got_e.board));
    end else begin
      void'(sb_q.pop_front());
    end
    @(posedge clk_i);
    #1;
    check($sformatf("v%0d.done_pulse_1cyc", idx), 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones, accs;
    vecs[0]  = '{1'b1, 4'd4, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{1'b0, 4'd4, 1'b1, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 4'd9, 1'b1, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 2'b00};
    vecs[4]  = '{1'b1, 4'd0, 1'b0, 1'b1, 2'b00};
    vecs[5]  = '{1'b0, 4'd3, 1'b1, 1'b1, 2'b00};
    vecs[6]  = '{1'b0, 4'd1, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{1'b0, 4'd4, 1'b1, 1'b1, 2'b00};
    vecs[8]  = '{1'b0, 4'd2, 1'b0, 1'b1, 2'b01};
    vecs[9]  = '{1'b0, 4'd5, 1'b1, 1'b0, 2'b01};
    vecs[10] = '{1'b1, 4'd0, 1'b0, 1'b1, 2'b00};
    vecs[11] = '{1'b0, 4'd1, 1'b1, 1'b1, 2'b00};
    vecs[12] = '{1'b0, 4'd2, 1'b0, 1'b1, 2'b00};
    vecs[13] = '{1'b0, 4'd4, 1'b1, 1'b1, 2'b00};
    vecs[14] = '{1'b0, 4'd3, 1'b0, 1'b1, 2'b00};
    vecs[15] = '{1'b0, 4'd5, 1'b1, 1'b1, 2'b00};
    vecs[16] = '{1'b0, 4'd7, 1'b0, 1'b1, 2'b00};
    vecs[17] = '{1'b0, 4'd6, 1'b1, 1'b1, 2'b00};
    vecs[18] = '{1'b0, 4'd8, 1'b0, 1'b1, 2'b11};
    vecs[19] = '{1'b0, 4'd0, 1'b1, 1'b0, 2'b11};
    vecs[20] = '{1'b1, 4'd0, 1'b0, 1'b1, 2'b00};
    vecs[21] = '{1'b0, 4'd1, 1'b1, 1'b1, 2'b00};
    vecs[22] = '{1'b0, 4'd2, 1'b0, 1'b1, 2'b00};
    vecs[23] = '{1'b0, 4'd4, 1'b1, 1'b1, 2'b00};
    vecs[24] = '{1'b0, 4'd3, 1'b0, 1'b1, 2'b00};
    vecs[25] = '{1'b0, 4'd5, 1'b1, 1'b1, 2'b00};
    vecs[26] = '{1'b0, 4'd7, 1'b0, 1'b1, 2'b00};
    vecs[27] = '{1'b0, 4'd8, 1'b1, 1'b1, 2'b00};
    vecs[28] = '{1'b0, 4'd6, 1'b0, 1'b1, 2'b01};

    move_i = 4'd0;
    player_i = 1'b0;
    do_reset();
    check_zero_outputs("reset");

    // Reset asserted while the move sits in EVAL: board already written, then discarded.
    move_i = 4'd4; player_i = 1'b0; move_valid_i = 1'b1;
    @(posedge clk_i); #1 move_valid_i = 1'b0;
    check("mid.busy", 32'(busy_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    check("mid.eval_count", 32'(move_count_o), 32'd1);
    check("mid.eval_board", 32'(board_o[9:8]), 32'd1);
    check("mid.eval_outcome", 32'(outcome_o), 32'd0);
    rst_i = 1'b1;
    dones = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) dones++;
    end
    rst_i = 1'b0;
    check_zero_outputs("mid_rst");
    @(posedge clk_i);
    #1;
    if (done_o) dones++;
    check("mid.no_done", 32'(dones), 32'd0);
    m_board = 18'd0;
    m_count = 4'd0;

    for (int i = 0; i < 29; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_vec(i, vecs[i].mv, vecs[i].pl, vecs[i].acc, vecs[i].outc);
    end

    // move_valid held high: one response per IDLE entry, only the first legal.
    do_reset();
    move_i = 4'd4; player_i = 1'b0; move_valid_i = 1'b1;
    dones = 0; accs = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) dones++;
      if (accepted_o) accs++;
    end
    move_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) dones++;
    end
    check("hold.dones", 32'(dones), 32'd3);
    check("hold.accepts", 32'(accs), 32'd1);
    check("hold.count", 32'(move_count_o), 32'd1);

    // A pulse of move_valid during WRITE must be ignored.
    move_i = 4'd0; player_i = 1'b1; move_valid_i = 1'b1;
    dones = 0;
    @(posedge clk_i); #1 move_valid_i = 1'b0;
    check("pulse.busy", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    move_i = 4'd8; player_i = 1'b0; move_valid_i = 1'b1;
    @(posedge clk_i); #1 move_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) dones++;
    end
    check("pulse.dones", 32'(dones), 32'd1);
    check("pulse.count", 32'(move_count_o), 32'd2);
    check("pulse.sq0", 32'(board_o[1:0]), 32'd2);
    check("pulse.sq8", 32'(board_o[17:16]), 32'd0);
    check("pulse.busy_end", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_checker.md
# board_checker

Move-resolution stage directly downstream of the tic-tac-toe turn FSM. It holds the 3x3 board, validates each move request (square range, occupancy, turn order, game state), commits legal moves, and evaluates all eight lines for a win or tie. It returns a one-cycle `done` pulse with accept/reject status and a sticky game outcome, which the turn FSM consumes in its CHECK state to choose the next player or end the game.

## Interface
- No parameters; the board is fixed at 9 squares.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high. Clears the board, counter and outcome, and forces IDLE.
- `move_valid` in 1: request strobe, sampled only in IDLE and OVER.
- `move` in 4: square index, row-major, 0 = top-left to 8 = bottom-right.
- `player` in 1: 0 = user 1 (mark 01), 1 = user 2 (mark 10).
- `busy` out 1: high in CHECK, WRITE, EVAL and RESP.
- `done` out 1: one-cycle pulse; the response is valid in this cycle.
- `accepted` out 1: meaningful only while `done` = 1. 1 = move committed; 0 = rejected.
- `outcome` out 2: 00 = in progress, 01 = user 1 wins, 10 = user 2 wins, 11 = tie. Sticky until `rst`.
- `game_over` out 1: high whenever `outcome` != 00.
- `board` out 18: 2 bits per square, square k at [2k+1:2k]. 00 = empty, 01 = user 1, 10 = user 2.
- `move_count` out 4: number of committed moves, 0–9.

## Operation
- **States:** IDLE, CHECK, WRITE, EVAL, RESP, OVER.
- **IDLE:** if `move_valid` = 1, latch `move` and `player` into internal registers and go to CHECK. Otherwise stay.
- **CHECK:** the move is legal only if all of the following hold:
  - latched `move` <= 8;
  - the addressed square is 00;
  - latched `player` == `move_count[0]` (user 1 always moves first).
  - Legal: go to WRITE, with accept flag = 1.
  - Illegal: go to RESP, with accept flag = 0.
- **WRITE:** write the player's mark into the square, increment `move_count`, go to EVAL.
- **EVAL:** check the 8 lines (3 rows, 3 columns, 2 diagonals).
  - Any line of three 01 → `outcome` = 01.
  - Any line of three 10 → `outcome` = 10.
  - Otherwise, if `move_count` == 9 → `outcome` = 11.
  - A win on the 9th move is reported as a win, never as a tie.
  - Go to RESP.
- **RESP:** `done` = 1, `accepted` = latched accept flag. Next state is OVER if `outcome` != 00, else IDLE.
- **OVER:** board and outcome are frozen. A `move_valid` here goes to RESP with accept flag = 0, then returns to OVER.
- **Requests while busy:** `move_valid` asserted in CHECK through RESP is ignored; there is no queuing. The upstream FSM must wait for `done`.
- **Rejections:** a rejected move never modifies `board`, `move_count` or `outcome`.

## Timing
- **Reset:** the cycle after `rst` is sampled high:
  - state = IDLE;
  - `board` = 0, `move_count` = 0, `outcome` = 00;
  - `busy` = 0, `done` = 0, `accepted` = 0, `game_over` = 0.
- **Legal move** (request sampled at edge E0):
  - CHECK after E0, WRITE after E1, EVAL after E2, RESP after E3.
  - `done` is high for exactly the cycle following E3.
  - `board` and `move_count` update at E2; `outcome` updates at E3.
- **Illegal move, or any request in OVER:** RESP after E1, so `done` is high in the cycle after E1.
- **Back-to-back requests:** IDLE accepts a new request on the first edge after RESP, giving at most one move per 5 cycles.
- **`rst` mid-operation:** abort at the next edge, with no `done` pulse. A partially processed move is discarded, even after WRITE.
- **Derived outputs:** `busy` and `game_over` are decoded from registered state, so they have no combinational path from the inputs.

## Test plan
- **Reset:** drive `rst` = 1 for 2 cycles mid-EVAL → all outputs zero, and no `done` pulse.
- **Legal first move:** `move` = 4, `player` = 0 → `done` 4 edges later, `accepted` = 1, `board[9:8]` = 01, `move_count` = 1, `outcome` = 00.
- **Illegal requests**, each → `done` after 2 edges with `accepted` = 0 and board unchanged:
  - occupied square 4;
  - `move` = 9;
  - `player` = 0 when user 2 is due.
- **Row win:** user 1 plays 0, 1, 2 and user 2 plays 3, 4 → the final `done` has `accepted` = 1, `outcome` = 01, `game_over` = 1. A further request → `accepted` = 0 and the outcome stays 01.
- **Tie:** the full sequence 0, 1, 2, 4, 3, 5, 7, 6, 8 (alternating players) → `outcome` = 11 and `move_count` = 9. A variant where the 9th move completes a line → `outcome` = 01, not 11.
- **Busy and spurious requests:**
  - Holding `move_valid` high through a request → exactly one `done` per IDLE entry.
  - A pulse of `move_valid` while `busy` = 1 → ignored.
